// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: sequences one execute-stage load/store at a time onto the shared
// system bus, stalling the pipeline while the bus cycle is in flight, steering
// byte/half lanes and returning extended load data as a register write.
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_we_i,
  input  logic [4:0]  rd_addr_i,
  output logic        stall_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       op_q;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  logic [4:0]       rd_q;

  logic             reg_we_q;
  logic [4:0]       reg_waddr_q;
  logic [31:0]      reg_wdata_q;
  logic             misalign_q;
  logic             bus_err_q;

  logic             op_valid;
  logic             op_misaligned;
  logic             accept;
  logic             busy;
  logic             timeout_hit;
  logic             done_ok;
  logic             done_err;
  logic             op_is_load;
  logic [1:0]       lane;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_data;
  logic [3:0]       sel;
  logic [31:0]      wdata;
  logic             we;

  // Direction is fully encoded by the op code; mem_we_i carries no extra information.
  logic unused_mem_we;
  assign unused_mem_we = mem_we_i;

  // Classify the incoming op: recognised, and whether its address breaks natural alignment.
  always_comb begin
    op_valid      = 1'b0;
    op_misaligned = 1'b0;
    case (mem_op_i)
      OP_LB, OP_LBU, OP_SB: op_valid = 1'b1;
      OP_LH, OP_LHU, OP_SH: begin
        op_valid      = 1'b1;
        op_misaligned = mem_addr_i[0];
      end
      OP_LW, OP_SW: begin
        op_valid      = 1'b1;
        op_misaligned = |mem_addr_i[1:0];
      end
      default: ;
    endcase
  end

  assign accept      = (state_q == ST_IDLE) && op_valid && !op_misaligned;
  assign busy        = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 32'd1));
  assign lane        = addr_q[1:0];
  assign op_is_load  = (op_q == OP_LB) || (op_q == OP_LH) || (op_q == OP_LW) ||
                       (op_q == OP_LBU) || (op_q == OP_LHU);

  // Next state; an ack in the last allowed cycle still completes normally.
  always_comb begin
    state_d  = state_q;
    done_ok  = 1'b0;
    done_err = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ: begin
        if (bus_gnt_i && bus_ack_i) begin
          state_d = ST_DONE;
          done_ok = 1'b1;
        end else if (timeout_hit) begin
          state_d  = ST_DONE;
          done_err = 1'b1;
        end else if (bus_gnt_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus_ack_i) begin
          state_d = ST_DONE;
          done_ok = 1'b1;
        end else if (timeout_hit) begin
          state_d  = ST_DONE;
          done_err = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Store lane steering from the latched op; loads always read the full word.
  always_comb begin
    sel   = 4'hF;
    wdata = 32'd0;
    we    = 1'b0;
    case (op_q)
      OP_SB: begin
        sel   = 4'b0001 << lane;
        wdata = {4{data_q[7:0]}};
        we    = 1'b1;
      end
      OP_SH: begin
        sel   = 4'b0011 << {lane[1], 1'b0};
        wdata = {2{data_q[15:0]}};
        we    = 1'b1;
      end
      OP_SW: begin
        wdata = data_q;
        we    = 1'b1;
      end
      default: ;
    endcase
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    rd_byte   = bus_rdata_i[{lane, 3'b000} +: 8];
    rd_half   = bus_rdata_i[{lane[1], 4'b0000} +: 16];
    load_data = 32'd0;
    case (op_q)
      OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data = {24'd0, rd_byte};
      OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_data = {16'd0, rd_half};
      OP_LW:   load_data = bus_rdata_i;
      default: load_data = 32'd0;
    endcase
  end

  // State register, request latch and REQ/WAIT cycle counter.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      rd_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= mem_op_i;
        addr_q <= mem_addr_i;
        data_q <= mem_data_i;
        rd_q   <= rd_addr_i;
        cnt_q  <= '0;
      end else if (busy) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Registered one-cycle writeback, misalign and timeout pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      reg_we_q    <= 1'b0;
      reg_waddr_q <= 5'd0;
      reg_wdata_q <= 32'd0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      reg_we_q   <= done_ok && op_is_load;
      misalign_q <= (state_q == ST_IDLE) && op_valid && op_misaligned;
      bus_err_q  <= done_err;
      if (done_ok && op_is_load) begin
        reg_waddr_q <= rd_q;
        reg_wdata_q <= load_data;
      end
    end
  end

  assign stall_o     = accept || busy;
  assign reg_we_o    = reg_we_q;
  assign reg_waddr_o = reg_waddr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign misalign_o  = misalign_q;
  assign bus_err_o   = bus_err_q;
  assign bus_req_o   = busy;
  assign bus_addr_o  = busy ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus_wdata_o = busy ? wdata : 32'd0;
  assign bus_we_o    = busy && we;
  assign bus_sel_o   = busy ? sel : 4'd0;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl: directed and randomized load/store traffic against a
// transaction-level reference of the load/store bus sequencer.
module tb_lsu_bus_ctrl;

  localparam int unsigned T_MAIN = 4;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic [4:0]  rd_addr;
  logic        bus_gnt;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  logic        stall, reg_we, misalign, bus_err, bus_req, bus_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata, bus_addr, bus_wdata;
  logic [3:0]  bus_sel;

  logic        z_stall, z_reg_we, z_misalign, z_bus_err, z_bus_req, z_bus_we;
  logic [4:0]  z_reg_waddr;
  logic [31:0] z_reg_wdata, z_bus_addr, z_bus_wdata;
  logic [3:0]  z_bus_sel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(T_MAIN)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .mem_op_i(mem_op), .mem_addr_i(mem_addr),
    .mem_data_i(mem_data), .mem_we_i(mem_we), .rd_addr_i(rd_addr),
    .stall_o(stall), .reg_we_o(reg_we), .reg_waddr_o(reg_waddr), .reg_wdata_o(reg_wdata),
    .misalign_o(misalign), .bus_err_o(bus_err), .bus_req_o(bus_req), .bus_gnt_i(bus_gnt),
    .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_we_o(bus_we), .bus_sel_o(bus_sel),
    .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata)
  );

  // Same stimulus, timeout disabled.
  lsu_bus_ctrl #(.TIMEOUT_CYCLES(0)) u_dut_noto (
    .clk_i(clk), .rst_n_i(rst_n), .mem_op_i(mem_op), .mem_addr_i(mem_addr),
    .mem_data_i(mem_data), .mem_we_i(mem_we), .rd_addr_i(rd_addr),
    .stall_o(z_stall), .reg_we_o(z_reg_we), .reg_waddr_o(z_reg_waddr), .reg_wdata_o(z_reg_wdata),
    .misalign_o(z_misalign), .bus_err_o(z_bus_err), .bus_req_o(z_bus_req), .bus_gnt_i(bus_gnt),
    .bus_addr_o(z_bus_addr), .bus_wdata_o(z_bus_wdata), .bus_we_o(z_bus_we), .bus_sel_o(z_bus_sel),
    .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_load(input logic [3:0] op);
    return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
  endfunction

  function automatic bit is_store(input logic [3:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  function automatic int unsigned size_of(input logic [3:0] op);
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    if (op == OP_LW || op == OP_SW) return 4;
    return 1;
  endfunction

  function automatic bit misaligned_ref(input logic [3:0] op, input logic [31:0] addr);
    return (addr % 32'(size_of(op))) != 32'd0;
  endfunction

  function automatic logic [3:0] exp_sel(input logic [3:0] op, input logic [31:0] addr);
    int unsigned a = addr % 4;
    if (!is_store(op)) return 4'hF;
    if (size_of(op) == 1) return 4'(1 << a);
    if (size_of(op) == 2) return 4'(3 << (a / 2 * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [3:0] op, input logic [31:0] data);
    if (size_of(op) == 1) return (data & 32'hFF) * 32'h0101_0101;
    if (size_of(op) == 2) return (data & 32'hFFFF) * 32'h0001_0001;
    return data;
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int unsigned a = addr % 4;
    logic [31:0] b = (rdata >> (8 * a)) & 32'hFF;
    logic [31:0] h = (rdata >> (16 * (a / 2))) & 32'hFFFF;
    case (op)
      OP_LB:   return (b >= 32'd128) ? b - 32'd256 : b;
      OP_LBU:  return b;
      OP_LH:   return (h >= 32'd32768) ? h - 32'd65536 : h;
      OP_LHU:  return h;
      default: return rdata;
    endcase
  endfunction

  // One instruction: grant in busy cycle g, ack in busy cycle a (a >= g), then DONE.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] rd, input int g, input int a, input logic [31:0] rdata);
    bit mis;
    bit timed_out;
    int n_busy;
    mis = misaligned_ref(op, addr);
    @(negedge clk);
    mem_op = op; mem_addr = addr; mem_data = data; mem_we = is_store(op); rd_addr = rd;
    bus_gnt = 1'b0; bus_ack = 1'b0; bus_rdata = $urandom;
    #1;
    check_eq("accept_stall", 64'(stall), 64'(!mis));
    check_eq("accept_req", 64'(bus_req), 64'd0);
    check_eq("accept_pulses", 64'({misalign, bus_err, reg_we}), 64'd0);
    if (mis) begin
      @(negedge clk);
      mem_op = OP_NOP;
      #1;
      check_eq("misalign_pulse", 64'(misalign), 64'd1);
      check_eq("misalign_quiet", 64'({stall, bus_req, reg_we, bus_err}), 64'd0);
      return;
    end
    timed_out = (a > int'(T_MAIN));
    n_busy    = timed_out ? int'(T_MAIN) : a;
    for (int c = 1; c <= n_busy; c++) begin
      @(negedge clk);
      bus_gnt   = (c == g);
      bus_ack   = (c == a);
      bus_rdata = (c == a) ? rdata : $urandom;
      #1;
      check_eq("busy_ctl", 64'({stall, bus_req, bus_we, reg_we, bus_err}),
               64'({1'b1, 1'b1, is_store(op), 1'b0, 1'b0}));
      check_eq("busy_addr", 64'(bus_addr), 64'(addr & 32'hFFFF_FFFC));
      check_eq("busy_sel", 64'(bus_sel), 64'(exp_sel(op, addr)));
      if (is_store(op)) check_eq("busy_wdata", 64'(bus_wdata), 64'(exp_wdata(op, data)));
    end
    @(negedge clk);
    bus_gnt = 1'b0; bus_ack = 1'b0; bus_rdata = $urandom;
    #1;
    check_eq("done_bus_ctl", 64'({bus_req, bus_we, bus_sel}), 64'd0);
    check_eq("done_bus_data", {bus_addr, bus_wdata}, 64'd0);
    check_eq("done_stall", 64'(stall), 64'd0);
    check_eq("done_err", 64'(bus_err), 64'(timed_out));
    check_eq("done_we", 64'(reg_we), 64'(is_load(op) && !timed_out));
    if (is_load(op) && !timed_out) begin
      check_eq("done_waddr", 64'(reg_waddr), 64'(rd));
      check_eq("done_wdata", 64'(reg_wdata), 64'(exp_load(op, addr, rdata)));
    end
    @(negedge clk);
    mem_op = OP_NOP;
    #1;
    check_eq("no_reissue", 64'({stall, bus_req, reg_we, bus_err}), 64'd0);
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    rst_n = 1'b0; mem_op = OP_NOP; bus_gnt = 1'b0; bus_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Hang guard.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] ops [8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    int err_seen;
    int stall_low;
    int req_low;

    rst_n = 1'b0; mem_op = OP_NOP; mem_addr = 32'd0; mem_data = 32'd0; mem_we = 1'b0;
    rd_addr = 5'd0; bus_gnt = 1'b0; bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_ctl", 64'({stall, reg_we, misalign, bus_err, bus_req, bus_we, bus_sel}), 64'd0);
    check_eq("reset_bus", {bus_addr, bus_wdata}, 64'd0);
    check_eq("reset_wb", 64'({reg_waddr, reg_wdata}), 64'd0);
    rst_n = 1'b1;

    do_op(OP_LW,  32'h100, 32'd0,         5'd3, 1, 2, 32'hDEAD_BEEF);
    do_op(OP_LB,  32'h203, 32'd0,         5'd4, 1, 2, 32'h80FF_0000);
    do_op(OP_LBU, 32'h203, 32'd0,         5'd5, 2, 2, 32'h80FF_0000);
    do_op(OP_SH,  32'h302, 32'h1234_ABCD, 5'd6, 1, 3, 32'd0);
    do_op(OP_LW,  32'h101, 32'd0,         5'd7, 1, 2, 32'd0);
    do_op(OP_LW,  32'h400, 32'd0,         5'd8, 99, 99, 32'd0);
    do_op(OP_LH,  32'h502, 32'd0,         5'd9, 1, int'(T_MAIN), 32'h8001_7FFF);

    // Reset while waiting for ack abandons the load.
    @(negedge clk);
    mem_op = OP_LW; mem_addr = 32'h180; rd_addr = 5'd10; mem_we = 1'b0;
    #1;
    check_eq("rw_accept", 64'(stall), 64'd1);
    @(negedge clk);
    bus_gnt = 1'b1;
    #1;
    check_eq("rw_req", 64'(bus_req), 64'd1);
    @(negedge clk);
    bus_gnt = 1'b0; rst_n = 1'b0; mem_op = OP_NOP;
    #1;
    check_eq("rw_wait", 64'({bus_req, stall}), 64'b11);
    @(negedge clk);
    rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    #1;
    check_eq("rw_after_reset", 64'({bus_req, stall, reg_we, bus_err}), 64'd0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check_eq("rw_no_wb", 64'({reg_we, bus_err, bus_req}), 64'd0);
    do_op(OP_LW, 32'h180, 32'd0, 5'd10, 1, 2, 32'h1357_9BDF);

    // Timeout disabled: stall holds indefinitely without a grant.
    reset_cycle();
    mem_op = OP_LW; mem_addr = 32'h40; rd_addr = 5'd1; mem_we = 1'b0;
    #1;
    check_eq("noto_accept", 64'(z_stall), 64'd1);
    err_seen = 0; stall_low = 0; req_low = 0;
    repeat (60) begin
      @(negedge clk);
      #1;
      if (!z_stall) stall_low++;
      if (!z_bus_req) req_low++;
      if (z_bus_err) err_seen++;
    end
    check_eq("noto_stall_held", 64'(stall_low), 64'd0);
    check_eq("noto_req_held", 64'(req_low), 64'd0);
    check_eq("noto_no_err", 64'(err_seen), 64'd0);
    reset_cycle();

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic [3:0]  op;
      logic [31:0] addr;
      int g;
      op   = ops[$urandom_range(0, 7)];
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(size_of(op)) - 32'd1);
      g = $urandom_range(1, 5);
      do_op(op, addr, $urandom, 5'($urandom), g, g + $urandom_range(0, 2), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        mem_op = OP_NOP;
        #1;
        check_eq("idle_gap", 64'({stall, bus_req, misalign, reg_we, bus_err}), 64'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
